// File: rtl/uart_mmio_pkg.sv
// uart_mmio shared definitions
// register offsets, FSM encodings, status bit positions
package uart_mmio_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_RXDATA = 2'd2;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_rx.sv
// uart_rx: synchroniser, 8N1 receive FSM, shift register
// emits a captured byte with a one-cycle done pulse
module uart_rx
  import uart_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;

  // two-flop synchroniser, idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // receive FSM next state; a short start bit is dropped as a glitch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            byte_d = shreg_q;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // receive FSM state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  assign byte_o = byte_q;
  assign done_o = done_q;

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the core data port
// TX FSM, register file and address decode; RX in uart_rx
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  input  logic        rx,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic       hit;
  logic [1:0] sel;
  logic       tx_busy;
  logic       tx_accept;
  logic       rd_rx;
  logic       clr_ovr;
  logic [7:0] rx_new;
  logic       rx_done;
  logic       unused_ok;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    txsh_q, txsh_d;
  logic          tx_q, tx_d;

  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  assign hit       = (address[31:4] == BASE[31:4]);
  assign sel       = address[3:2];
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx_accept = store && hit && (sel == UART_TXDATA) && !tx_busy;
  assign rd_rx     = load && hit && (sel == UART_RXDATA);
  assign clr_ovr   = store && hit && (sel == UART_STATUS)
                   && store_data[ST_RX_OVERRUN];
  assign unused_ok = ^{address[1:0], store_data[31:8]};

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock  (clock),
    .reset  (reset),
    .rx_i   (rx),
    .byte_o (rx_new),
    .done_o (rx_done)
  );

  // transmit FSM next state; tx line value registered with the state
  always_comb begin
    tx_state_d = tx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    txsh_d     = txsh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (tx_accept) begin
          tx_state_d = TX_START;
          txsh_d     = store_data[7:0];
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (baud_q == FULL) begin
          baud_d     = '0;
          tx_state_d = TX_DATA;
          tx_d       = txsh_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == FULL) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          txsh_d = {1'b0, txsh_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_d = txsh_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (baud_q == FULL) begin
          baud_d     = '0;
          tx_state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // transmit FSM state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      txsh_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      txsh_q     <= txsh_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // receive holding register; a same-cycle read makes room for a new byte
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_byte_d  = rx_byte_q;
    if (rd_rx) rx_valid_d = 1'b0;
    if (clr_ovr) rx_ovr_d = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rd_rx) begin
        rx_byte_d  = rx_new;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // receive status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // combinational read mux
  always_comb begin
    load_data = '0;
    if (load && hit) begin
      unique case (sel)
        UART_STATUS: load_data = {29'b0, rx_ovr_q, rx_valid_q, tx_busy};
        UART_RXDATA: load_data = {24'b0, rx_byte_q};
        default:     load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed self-checking bench for uart_mmio
// CLKS_PER_BIT = 4, expected values hand-computed
module tb_uart_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          CPB  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic        store;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        rx;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [9:0] fr_a5;

  uart_mmio #(
    .BASE        (BASE),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .store     (store),
    .address   (address),
    .store_data(store_data),
    .load_data (load_data),
    .rx        (rx),
    .tx        (tx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; checks comb read then finishes the cycle
  task automatic rd(input string tag, input logic [3:0] off,
                    input logic [31:0] exp);
    load    = 1'b1;
    address = BASE + {28'b0, off};
    #1;
    chk(tag, load_data, exp);
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    store      = 1'b1;
    address    = BASE + {28'b0, off};
    store_data = d;
    @(negedge clock);
    store = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      repeat (CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    store      = 1'b0;
    address    = '0;
    store_data = '0;
    rx         = 1'b1;
    fr_a5      = {1'b1, 8'hA5, 1'b0};

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("tx_in_reset", {31'b0, tx}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clock);
    rd("status_after_reset", 4'h4, 32'h0);
    rd("txdata_reads_zero", 4'h0, 32'h0);

    // frame 0xA5 with a dropped write while busy
    wr(4'h0, 32'h0000_00A5);
    for (int i = 0; i < 40; i++) begin
      load    = 1'b1;
      address = BASE + 32'h4;
      if (i == 5) begin
        load       = 1'b0;
        store      = 1'b1;
        address    = BASE;
        store_data = 32'hFF;
      end
      #1;
      chk($sformatf("tx_a5_%0d", i), {31'b0, tx}, {31'b0, fr_a5[i/4]});
      if (i != 5) chk($sformatf("busy_%0d", i), load_data, 32'h1);
      @(negedge clock);
      store = 1'b0;
    end
    load    = 1'b1;
    address = BASE + 32'h4;
    #1;
    chk("busy_drops", load_data, 32'h0);
    chk("tx_idle_after", {31'b0, tx}, 32'd1);
    #1;
    load       = 1'b0;
    store      = 1'b1;
    address    = BASE;
    store_data = 32'h5A;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      store = 1'b0;
      #1;
      if (i == 0) chk("tx_5a_start", {31'b0, tx}, 32'd0);
      if (i == 4) chk("tx_5a_b0", {31'b0, tx}, 32'd0);
      if (i == 8) chk("tx_5a_b1", {31'b0, tx}, 32'd1);
      if (i == 39) chk("tx_5a_stop", {31'b0, tx}, 32'd1);
    end
    @(negedge clock);
    rd("busy_after_5a", 4'h4, 32'h0);

    // single receive
    send(8'h3C, 1'b1);
    load    = 1'b0;
    address = BASE + 32'h4;
    #1;
    chk("no_load_zero", load_data, 32'h0);
    @(negedge clock);
    rd("status_rx", 4'h4, 32'h2);
    rd("rxdata_3c", 4'h8, 32'h3C);
    rd("status_cleared", 4'h4, 32'h0);

    // overrun
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd("status_ovr", 4'h4, 32'h6);
    rd("rxdata_11", 4'h8, 32'h11);
    rd("status_ovr_only", 4'h4, 32'h4);
    wr(4'h4, 32'h4);
    rd("status_ovr_clr", 4'h4, 32'h0);

    // glitch and framing error
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (12) @(negedge clock);
    rd("glitch", 4'h4, 32'h0);
    send(8'h55, 1'b0);
    rd("framing", 4'h4, 32'h0);

    // decode boundaries
    rd("reserved_c", 4'hC, 32'h0);
    load    = 1'b1;
    address = BASE + 32'h10;
    #1;
    chk("miss_base_10", load_data, 32'h0);
    @(negedge clock);
    load = 1'b0;

    // reset mid-frame
    wr(4'h0, 32'h0000_0000);
    repeat (10) @(negedge clock);
    #1;
    chk("tx_mid_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("tx_reset_mid", {31'b0, tx}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    rd("status_post_rst", 4'h4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
